axi_wr_arbiter: RTL



---
 rtl/axi_pkg.sv | 16 +
 rtl/rr_pick.sv | 24 ++
 rtl/axi_wr_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions: response codes and the write-arbiter state encoding.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: the search starts one past ptr and wraps;
// the first set request bit wins.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!grant_valid && req[(int'(ptr) + off) % N_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(ptr) + off) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter serialising whole AXI-lite write transactions from
// N_REQ requesters onto one write master.
//   state | meaning
//   IDLE  | sample req_valid, latch winner payload and grant_id
//   ISSUE | one-cycle m_valid pulse
//   WAIT  | hold payload until m_ready, capture m_bresp
//   DONE  | pulse req_done[grant_id], advance round-robin pointer
module axi_wr_arbiter
  import axi_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  input  logic [N_REQ*DATA_W/8-1:0]   req_strb,
  output logic [N_REQ-1:0]            req_done,
  output logic [1:0]                  req_resp,
  output logic                        m_valid,
  output logic [ADDR_W-1:0]           m_aw_addr,
  output logic [DATA_W-1:0]           m_w_data,
  output logic [DATA_W/8-1:0]         m_w_strb,
  input  logic                        m_ready,
  input  logic [1:0]                  m_bresp,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);

  arb_state_t        state, next_state;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic [1:0]        resp_q;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req         (req_valid),
    .ptr         (ptr),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (pick_valid) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT:  if (m_ready) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Payload is latched once in IDLE so requesters cannot disturb an issued write.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      grant_q <= '0;
      resp_q  <= RESP_OKAY;
      ptr     <= IDX_W'(N_REQ - 1);
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        addr_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        data_q  <= req_data[pick_idx*DATA_W +: DATA_W];
        strb_q  <= req_strb[pick_idx*STRB_W +: STRB_W];
        grant_q <= pick_idx;
      end
      if (state == ST_WAIT && m_ready) resp_q <= m_bresp;
      if (state == ST_DONE)            ptr    <= grant_q;
    end
  end

  always_comb begin
    req_done = '0;
    if (state == ST_DONE) req_done[grant_q] = 1'b1;
  end

  assign req_resp  = (state == ST_DONE) ? resp_q : RESP_OKAY;
  assign m_valid   = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign m_aw_addr = addr_q;
  assign m_w_data  = data_q;
  assign m_w_strb  = strb_q;
  assign grant_id  = grant_q;

endmodule
